// File: rtl/upb_multi.sv
// upb_multi: sign-sign B-coefficient update pass plus DQ history shift (clk, reset, start/rate_in/DQn in, ld_* loads, busy/done/BnP/DQh out)
module upb_multi #(
  parameter int NCOEF = 6,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          rate_in,
  input  logic [CW-1:0]       DQn,
  input  logic                ld_en,
  input  logic [2:0]          ld_idx,
  input  logic [CW-1:0]       ld_data,
  output logic                busy,
  output logic                done,
  output logic [NCOEF*CW-1:0] BnP,
  output logic [NCOEF*CW-1:0] DQh
);
  typedef enum logic [1:0] {IDLE, UPD, SHIFT} state_t;
  state_t r_st;
  logic [NCOEF-1:0][CW-1:0] r_b, r_dq;
  logic [CW-1:0] r_dqc;
  logic [1:0] r_rate;
  logic [2:0] r_k;
  logic r_busy, r_done;
  logic [CW-1:0] w_b, w_ugb, w_sh, w_nb;
  assign w_b = r_b[r_k];
  assign w_ugb = ~|r_dqc[CW-2:0] ? '0 : (r_dqc[CW-1] ^ r_dq[r_k][CW-1]) ? 16'hFF80 : 16'h0080;
  assign w_sh = $signed(w_b) >>> (r_rate == 2'b00 ? 9 : 8);
  assign w_nb = w_b + w_ugb - w_sh;
  assign busy = r_busy;
  assign done = r_done;
  assign BnP = r_b;
  assign DQh = r_dq;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= IDLE;
      r_b <= '0;
      r_dq <= '0;
      r_dqc <= '0;
      r_rate <= '0;
      r_k <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        IDLE: begin
          if (ld_en && 32'(ld_idx) < NCOEF) r_b[ld_idx] <= ld_data;
          if (start) begin
            r_dqc <= DQn;
            r_rate <= rate_in;
            r_k <= '0;
            r_busy <= 1'b1;
            r_st <= UPD;
          end
        end
        UPD: begin
          r_b[r_k] <= w_nb;
          r_k <= r_k + 3'd1;
          if (32'(r_k) == NCOEF - 1) r_st <= SHIFT;
        end
        SHIFT: begin
          for (int i = NCOEF - 1; i > 0; i--) r_dq[i] <= r_dq[i-1];
          r_dq[0] <= r_dqc;
          r_k <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_st <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upb_multi.sv
// tb_upb_multi: randomized self-checking bench for upb_multi against a behavioural model
module tb_upb_multi;
  localparam int N = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] rate_in = '0;
  logic [15:0] DQn = '0;
  logic ld_en = 1'b0;
  logic [2:0] ld_idx = '0;
  logic [15:0] ld_data = '0;
  logic busy, done;
  logic [N*16-1:0] BnP, DQh;
  int checks = 0;
  int errors = 0;
  logic [15:0] mb [N];
  logic [15:0] mdq [N];
  upb_multi #(.NCOEF(N), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rate_in(rate_in), .DQn(DQn),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .busy(busy), .done(done), .BnP(BnP), .DQh(DQh)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [N*16-1:0] got, input logic [N*16-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [N*16-1:0] flat(input logic [15:0] a [N]);
    logic [N*16-1:0] f;
    for (int k = 0; k < N; k++) f[k*16 +: 16] = a[k];
    return f;
  endfunction
  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      mb[k] = '0;
      mdq[k] = '0;
    end
  endtask
  task automatic m_pass(input logic [15:0] dqn, input logic [1:0] rate);
    for (int k = 0; k < N; k++) begin
      int b, g, lk;
      b = int'($signed(mb[k]));
      g = (dqn[14:0] == 0) ? 0 : (dqn[15] != mdq[k][15]) ? -128 : 128;
      lk = b >>> ((rate == 2'b00) ? 9 : 8);
      mb[k] = 16'(b + g - lk);
    end
    for (int k = N - 1; k > 0; k--) mdq[k] = mdq[k-1];
    mdq[0] = dqn;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b1;
    ld_en = 1'b1;
    ld_idx = 3'd0;
    ld_data = 16'h1234;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    ld_en = 1'b0;
    m_reset();
  endtask
  task automatic load(input logic [2:0] idx, input logic [15:0] data);
    ld_en = 1'b1;
    ld_idx = idx;
    ld_data = data;
    step();
    ld_en = 1'b0;
    if (idx < N) mb[idx] = data;
    chk("load_bnp", BnP, flat(mb));
  endtask
  task automatic start_pass(input logic [15:0] dqn, input logic [1:0] rate,
                            input logic ld, input logic [2:0] idx, input logic [15:0] data);
    start = 1'b1;
    DQn = dqn;
    rate_in = rate;
    ld_en = ld;
    ld_idx = idx;
    ld_data = data;
    if (ld && idx < N) mb[idx] = data;
    m_pass(dqn, rate);
    step();
    start = 1'b0;
    ld_en = 1'b0;
    DQn = $urandom;
    rate_in = 2'($urandom);
  endtask
  task automatic wait_done(input logic junk);
    int n, nb;
    n = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      step();
      n++;
      if (busy) nb++;
      if (junk && n == 2) begin
        start = 1'b1;
        ld_en = 1'b1;
        ld_idx = 3'($urandom_range(0, N - 1));
        ld_data = $urandom;
      end
      if (n == 3) begin
        start = 1'b0;
        ld_en = 1'b0;
      end
    end
    chk("latency", 96'(n), 96'(N + 1));
    chk("busy_cycles", 96'(nb), 96'(N + 1));
    chk("bnp", BnP, flat(mb));
    chk("dqh", DQh, flat(mdq));
  endtask
  initial begin
    int n;
    do_reset();
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_bnp", BnP, '0);
    chk("rst_dqh", DQh, '0);
    start_pass(16'h0005, 2'b01, 1'b0, 3'd0, 16'h0);
    chk("busy_after_start", 96'(busy), 96'(1));
    wait_done(1'b0);
    chk("r28_bnp", BnP, {N{16'h0080}});
    chk("r28_tap0", 96'(DQh[15:0]), 96'(16'h0005));
    start_pass(16'h8003, 2'b01, 1'b0, 3'd0, 16'h0);
    chk("done_one_cycle", 96'(done), 96'(0));
    wait_done(1'b0);
    chk("r29_bnp", BnP, '0);
    chk("r29_taps", 96'(DQh[31:0]), 96'({16'h0005, 16'h8003}));
    load(3'd0, 16'h4000);
    start_pass(16'h8000, 2'b00, 1'b0, 3'd0, 16'h0);
    wait_done(1'b0);
    chk("leak9", 96'(BnP[15:0]), 96'(16'h3FE0));
    load(3'd0, 16'h4000);
    start_pass(16'h8000, 2'b01, 1'b0, 3'd0, 16'h0);
    wait_done(1'b0);
    chk("leak8", 96'(BnP[15:0]), 96'(16'h3FC0));
    start_pass(16'h8000, 2'b01, 1'b1, 3'd0, 16'hC000);
    wait_done(1'b0);
    chk("leak8_neg", 96'(BnP[15:0]), 96'(16'hC040));
    do_reset();
    load(3'd0, 16'h7FFF);
    load(3'd7, 16'hABCD);
    start_pass(16'h0001, 2'b01, 1'b0, 3'd0, 16'h0);
    wait_done(1'b0);
    chk("wrap", 96'(BnP[15:0]), 96'(16'h8000));
    for (int t = 0; t < 30; t++) begin
      logic [15:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[14:0] = '0;
      if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), $urandom);
      start_pass(d, 2'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom);
      wait_done(t % 3 == 0);
    end
    for (int t = 0; t < 4; t++) begin
      start_pass($urandom, 2'($urandom), 1'b0, 3'd0, 16'h0);
      wait_done(1'b1);
    end
    start_pass(16'h1234, 2'b10, 1'b0, 3'd0, 16'h0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_reset();
    chk("abort_busy", 96'(busy), 96'(0));
    chk("abort_done", 96'(done), 96'(0));
    chk("abort_bnp", BnP, '0);
    chk("abort_dqh", DQh, '0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done || busy) n++;
    end
    chk("abort_no_done", 96'(n), 96'(0));
    start_pass(16'h0042, 2'b00, 1'b1, 3'd2, 16'h0100);
    wait_done(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/upb_multi.md
UPB_MULTI -- requirements
Module: upb_multi

Interface
REQ-001 Parameter NCOEF, default 6, SHALL set the number of B coefficients and DQ history taps (legal 1..8).
REQ-002 Parameter CW, default 16, SHALL set the coefficient and DQ word width (legal 16 only in this revision).
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL request one update pass; sampled only in IDLE.
REQ-006 rate_in  in  2  SHALL select the leak: 2'b00 uses shift 9, any other value uses shift 8.
REQ-007 DQn  in  CW  SHALL be the current quantized difference, sign-magnitude: bit 15 is the sign, [14:0] is the magnitude.
REQ-008 ld_en, ld_idx[2:0], ld_data[CW-1:0]  in  SHALL write coefficient ld_idx with ld_data; honoured only in IDLE.
REQ-009 busy  out  1  SHALL be high while a pass is in progress.
REQ-010 done  out  1  SHALL pulse for one cycle when a pass completes.
REQ-011 BnP  out  NCOEF*CW  SHALL expose the coefficients as a flat bus; coefficient k occupies [k*CW +: CW].
REQ-012 DQh  out  NCOEF*CW  SHALL expose the DQ history as a flat bus; tap k holds DQ(n-1-k).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, UPD and SHIFT.
REQ-014 In IDLE with start=1, the block SHALL capture DQn and rate_in into internal registers, clear index k to 0, and go to UPD.
REQ-015 In UPD, each cycle SHALL update coefficient k, increment k, and go to SHIFT after k=NCOEF-1.
  - Total: NCOEF cycles.
REQ-016 In SHIFT, the block SHALL do the following, then return to IDLE and assert done for the following cycle:
  - shift DQh by one tap (tap k+1 <= tap k);
  - write the captured DQn into tap 0;
  - discard the oldest tap.
REQ-017 Latency SHALL be NCOEF+2 edges: done is high in the cycle after edge NCOEF+1, counting the start-sampling edge as edge 0.
REQ-018 busy SHALL be high in UPD and SHIFT only; start outside IDLE SHALL be ignored.
REQ-019 start coincident with done SHALL be accepted, because the FSM is already in IDLE.
REQ-020 Sign term: U_k SHALL equal DQcap[15] XOR DQh tap k [15], using history as it stood before the SHIFT of this pass.
REQ-021 Gain UGB SHALL be:
  - 0 when DQcap[14:0] = 0;
  - 16'hFF80 when U_k = 1;
  - 16'h0080 otherwise.
REQ-022 Leak ULB SHALL equal the two's-complement negation of B_k arithmetically right-shifted by 9 (rate 00) or 8 (otherwise).
REQ-023 The new coefficient SHALL be B_k + UGB + ULB modulo 2^16, with no saturation; wrap-around is permitted.
REQ-024 ld_en in IDLE SHALL write ld_data into coefficient ld_idx at the next edge.
  - ld_idx >= NCOEF SHALL be ignored.
  - ld_en outside IDLE SHALL be ignored.
  - ld_en and start in the same IDLE cycle: the load SHALL take effect and the pass SHALL start, using the loaded value.
REQ-025 Coefficients and history SHALL change only via REQ-015, REQ-016, REQ-024 and reset.

Reset
REQ-026 reset=1 SHALL at the next edge:
  - force IDLE with k=0;
  - clear all coefficients, history and captured registers to 0;
  - drive busy=0 and done=0.
REQ-027 reset SHALL override start, ld_en and any in-progress pass; an aborted pass SHALL never produce done.

Verification
REQ-028 After reset, NCOEF=6, DQn=16'h0005, rate_in=01, start for one cycle -> busy high for 7 cycles, done at edge 8, every BnP coefficient = 16'h0080, DQh tap0 = 16'h0005.
REQ-029 Following REQ-028, DQn=16'h8003, start -> all coefficients = 16'h0000, tap0 = 16'h8003, tap1 = 16'h0005.
REQ-030 Load B0=16'h4000, DQn=16'h8000 (zero magnitude):
  - rate_in=00 -> B0 = 16'h3FE0;
  - repeat from 16'h4000 with rate_in=01 -> B0 = 16'h3FC0;
  - load 16'hC000 with rate_in=01 -> B0 = 16'hC040.
REQ-031 Load B0=16'h7FFF, history 0, DQn=16'h0001, rate_in=01 -> B0 = 16'h8000 (wrap, no saturation).
REQ-032 Start a pass, assert reset on the 3rd UPD cycle -> next edge: IDLE, all BnP and DQh = 0, busy = 0, no done pulse.
REQ-033 Assert start again in the done cycle, and assert start/ld_en while busy -> the re-start is accepted immediately; start/ld_en while busy are ignored and coefficients are unaffected.
